sha256_round_ctrl: RTL and testbench

Sequencer between `Message_Packer` and the SHA-256 compression core.
- Captures one padded 512-bit block from the packer's word stream.
- Generates the 64-entry message schedule on the fly and drives the core round by round.
- Latches the 256-bit digest, then optionally serializes it as 32 bytes to the UART transmitter.
- Single-block only: one packer block per hash.

---
 rtl/sha256_pkg.sv | 54 +++++
 rtl/sha256_msg_schedule.sv | 51 +++++
 rtl/sha256_round_ctrl.sv | 171 +++++++++++++++++
 tb/tb_sha256_round_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 constants, FSM encoding and schedule sigma functions
// Used by the round controller, the message schedule and the compression core.
package sha256_pkg;

  localparam int BLOCK_WORDS_DEF = 16;
  localparam int ROUNDS_DEF      = 64;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_ROUND     = 3'd2;
  localparam logic [2:0] ST_UPDATE    = 3'd3;
  localparam logic [2:0] ST_CAPTURE   = 3'd4;
  localparam logic [2:0] ST_SEND      = 3'd5;
  localparam logic [2:0] ST_SEND_WAIT = 3'd6;
  localparam logic [2:0] ST_DONE      = 3'd7;

  localparam logic [255:0] SHA256_H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // K_0 sits in the most significant word so the table reads in round order.
  localparam logic [2047:0] SHA256_K_TABLE = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sha256_k(input logic [5:0] t);
    return SHA256_K_TABLE[{6'd63 - t, 5'd0} +: 32];
  endfunction

  function automatic logic [31:0] sha256_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sha256_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - 16-slot circular message schedule with on-the-fly W_t expansion
// Slot t mod 16 is overwritten with W_t in the round that consumes it.
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic [3:0]            load_idx,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  round_en,
  input  logic [5:0]            round_idx,
  output logic [DATA_WIDTH-1:0] w_t
);

  logic [DATA_WIDTH-1:0] slot_q [16];
  logic [3:0]            idx_t, idx_m2, idx_m7, idx_m15;
  logic                  expand;
  logic [DATA_WIDTH-1:0] w_exp;

  // 4-bit wraparound turns t-2, t-7, t-15, t-16 into ring positions.
  assign idx_t   = round_idx[3:0];
  assign idx_m2  = idx_t - 4'd2;
  assign idx_m7  = idx_t - 4'd7;
  assign idx_m15 = idx_t - 4'd15;
  assign expand  = round_idx[5:4] != 2'b00;

  always_comb begin
    w_exp = sha256_sigma1(slot_q[idx_m2]) + slot_q[idx_m7]
          + sha256_sigma0(slot_q[idx_m15]) + slot_q[idx_t];
    w_t = '0;
    if (round_en) begin
      w_t = expand ? w_exp : slot_q[idx_t];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 16; i++) begin
        slot_q[i] <= '0;
      end
    end else if (load_en) begin
      slot_q[load_idx] <= load_data;
    end else if (round_en && expand) begin
      slot_q[idx_t] <= w_exp;
    end
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// rtl/sha256_round_ctrl.sv - block capture, round sequencing and digest latch for the SHA-256 core
// SHA256_TX_READBACK_EN adds byte-wise digest readback through the UART transmitter.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int ROUNDS      = ROUNDS_DEF,
  parameter int SKIP_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] mp_data_in,
  input  logic                  mp_dv_in,
  output logic                  core_init_out,
  output logic                  core_round_en_out,
  output logic [5:0]            round_idx_out,
  output logic [DATA_WIDTH-1:0] w_t_out,
  output logic                  core_update_out,
  input  logic [255:0]          core_digest_in,
  output logic [255:0]          digest_out,
  output logic                  digest_valid_out,
  output logic [7:0]            tx_byte_out,
  output logic                  tx_dv_out,
  input  logic                  tx_active_in,
  input  logic                  tx_done_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  err_out
);

  localparam logic [5:0] SKIP_CNT   = 6'(SKIP_FIRST);
  localparam logic [3:0] LAST_WORD  = 4'(BLOCK_WORDS - 1);
  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  logic [2:0]   state_q, state_d;
  logic [5:0]   dv_cnt_q, dv_cnt_d;
  logic [5:0]   round_q;
  logic [255:0] digest_q;
  logic         digest_valid_q;
  logic         dv_block_q;

  logic         start, dv_counting, load_en, last_word, in_round;
  logic [3:0]   load_idx;

  // A burst still high when the block returns to IDLE is a lost burst, not a new one.
  assign start       = (state_q == ST_IDLE) && mp_dv_in && !dv_block_q;
  assign dv_counting = start || ((state_q == ST_LOAD) && mp_dv_in);
  assign load_en     = dv_counting && (dv_cnt_q >= SKIP_CNT);
  assign load_idx    = 4'(dv_cnt_q - SKIP_CNT);
  assign last_word   = load_en && (load_idx == LAST_WORD);
  assign in_round    = state_q == ST_ROUND;

  sha256_msg_schedule #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sched (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .load_idx  (load_idx),
    .load_data (mp_data_in),
    .round_en  (in_round),
    .round_idx (round_q),
    .w_t       (w_t_out)
  );

`ifdef SHA256_TX_READBACK_EN
  logic [4:0]   byte_q;
  logic [255:0] byte_shift;
  logic         tx_issue;

  assign tx_issue    = (state_q == ST_SEND) && !tx_active_in;
  assign byte_shift  = digest_q >> {5'd31 - byte_q, 3'b000};
  assign tx_dv_out   = tx_issue;
  assign tx_byte_out = tx_issue ? byte_shift[7:0] : 8'd0;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      byte_q <= '0;
    end else if (state_q == ST_CAPTURE) begin
      byte_q <= '0;
    end else if ((state_q == ST_SEND_WAIT) && tx_done_in) begin
      byte_q <= byte_q + 5'd1;
    end
  end
`else
  logic unused_tx;
  assign unused_tx   = tx_active_in ^ tx_done_in;
  assign tx_dv_out   = 1'b0;
  assign tx_byte_out = 8'd0;
`endif

  always_comb begin
    state_d  = state_q;
    dv_cnt_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LOAD;
          dv_cnt_d = 6'd1;
        end
      end
      ST_LOAD: begin
        if (!mp_dv_in) begin
          state_d = ST_IDLE;
        end else if (last_word) begin
          state_d = ST_ROUND;
        end else begin
          dv_cnt_d = dv_cnt_q + 6'd1;
        end
      end
      ST_ROUND: begin
        if (round_q == LAST_ROUND) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE:  state_d = ST_CAPTURE;
`ifdef SHA256_TX_READBACK_EN
      ST_CAPTURE: state_d = ST_SEND;
      ST_SEND: begin
        if (tx_issue) begin
          state_d = ST_SEND_WAIT;
        end
      end
      ST_SEND_WAIT: begin
        if (tx_done_in) begin
          state_d = (byte_q == 5'd31) ? ST_DONE : ST_SEND;
        end
      end
`else
      ST_CAPTURE: state_d = ST_DONE;
`endif
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q        <= ST_IDLE;
      dv_cnt_q       <= '0;
      round_q        <= '0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      dv_block_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dv_cnt_q   <= dv_cnt_d;
      round_q    <= in_round ? round_q + 6'd1 : 6'd0;
      dv_block_q <= mp_dv_in &&
                    (dv_block_q || !((state_q == ST_IDLE) || (state_q == ST_LOAD)));
      if (state_q == ST_CAPTURE) begin
        digest_q       <= core_digest_in;
        digest_valid_q <= 1'b1;
      end else if (start) begin
        digest_valid_q <= 1'b0;
      end
    end
  end

  assign core_init_out     = start;
  assign core_round_en_out = in_round;
  assign round_idx_out     = in_round ? round_q : 6'd0;
  assign core_update_out   = state_q == ST_UPDATE;
  assign digest_out        = digest_q;
  assign digest_valid_out  = digest_valid_q;
  assign busy_out          = state_q != ST_IDLE;
  assign done_out          = state_q == ST_DONE;
  assign err_out           = (state_q == ST_LOAD) && !mp_dv_in;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb/tb_sha256_round_ctrl.sv - scoreboard bench for sha256_round_ctrl with a behavioural compression core
// Covers SHA256_TX_READBACK_EN when that macro is defined for the build.
module tb_sha256_round_ctrl;
  import sha256_pkg::*;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] DIG_ABC   =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [31:0]  mp_data_in;
  logic         mp_dv_in;
  logic         core_init_out, core_round_en_out, core_update_out;
  logic [5:0]   round_idx_out;
  logic [31:0]  w_t_out;
  logic [255:0] core_digest_in, digest_out;
  logic         digest_valid_out;
  logic [7:0]   tx_byte_out;
  logic         tx_dv_out, tx_active_in, tx_done_in;
  logic         busy_out, done_out, err_out;

  sha256_round_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mp_data_in        (mp_data_in),
    .mp_dv_in          (mp_dv_in),
    .core_init_out     (core_init_out),
    .core_round_en_out (core_round_en_out),
    .round_idx_out     (round_idx_out),
    .w_t_out           (w_t_out),
    .core_update_out   (core_update_out),
    .core_digest_in    (core_digest_in),
    .digest_out        (digest_out),
    .digest_valid_out  (digest_valid_out),
    .tx_byte_out       (tx_byte_out),
    .tx_dv_out         (tx_dv_out),
    .tx_active_in      (tx_active_in),
    .tx_done_in        (tx_done_in),
    .busy_out          (busy_out),
    .done_out          (done_out),
    .err_out           (err_out)
  );

  // Behavioural compression core driven by the controller's strobes.
  logic [255:0] core_h;
  logic [31:0]  va, vb, vc, vd, ve, vf, vg, vh, t1, t2;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  always_comb begin
    t1 = vh + (rotr(ve, 6) ^ rotr(ve, 11) ^ rotr(ve, 25)) + ((ve & vf) ^ (~ve & vg))
       + sha256_k(round_idx_out) + w_t_out;
    t2 = (rotr(va, 2) ^ rotr(va, 13) ^ rotr(va, 22)) + ((va & vb) ^ (va & vc) ^ (vb & vc));
  end

  always @(posedge clk) begin
    if (rst_n) begin
      core_h <= '0;
    end else if (core_init_out) begin
      core_h <= SHA256_H0;
      {va, vb, vc, vd, ve, vf, vg, vh} <= SHA256_H0;
    end else if (core_round_en_out) begin
      vh <= vg; vg <= vf; vf <= ve; ve <= vd + t1;
      vd <= vc; vc <= vb; vb <= va; va <= t1 + t2;
    end else if (core_update_out) begin
      core_h <= {core_h[255:224] + va, core_h[223:192] + vb, core_h[191:160] + vc,
                 core_h[159:128] + vd, core_h[127:96] + ve, core_h[95:64] + vf,
                 core_h[63:32] + vg, core_h[31:0] + vh};
    end
  end
  assign core_digest_in = core_h;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [255:0] exp_dig_q[$];
  logic [7:0]   exp_byte_q[$];

  int cyc = 0;
  int start_cyc, init_cyc, r0_cyc, upd_cyc, valid_cyc, done_cyc;
  int n_init = 0, n_rounds = 0, n_err = 0, n_strobe = 0, run_strobes = 0;
  int n_tx_viol = 0, first_strobe_cyc = -1, byte5_cyc = 0;
  int served = 0, last_done_cyc = 0, stall_end_cyc = 0;
  bit stall_en = 0, stall_seen = 0, valid_prev = 0;
  logic [31:0] w16;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (core_init_out) begin
      init_cyc = cyc;
      n_init++;
      run_strobes = 0;
    end
    if (core_round_en_out) begin
      n_rounds++;
      if (round_idx_out == 6'd0) r0_cyc = cyc;
      if (round_idx_out == 6'd16) w16 = w_t_out;
    end
    if (core_update_out) upd_cyc = cyc;
    if (digest_valid_out && !valid_prev) valid_cyc = cyc;
    valid_prev = digest_valid_out;
    if (err_out) n_err++;
    if (done_out) begin
      done_cyc = cyc;
      if (exp_dig_q.size() == 0) check_eq("sb_digest_depth", 256'(exp_dig_q.size()), 256'(1));
      else check_eq("digest", digest_out, exp_dig_q.pop_front());
      check_eq("valid_at_done", 256'(digest_valid_out), 256'(1));
    end
    if (tx_dv_out) begin
      n_strobe++;
      if (tx_active_in) n_tx_viol++;
      if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
      if (run_strobes == 5) byte5_cyc = cyc;
      run_strobes++;
      if (exp_byte_q.size() == 0) check_eq("sb_byte_depth", 256'(exp_byte_q.size()), 256'(1));
      else check_eq("tx_byte", 256'(tx_byte_out), 256'(exp_byte_q.pop_front()));
    end
  end

`ifdef SHA256_TX_READBACK_EN
  // UART model: busy for two cycles per byte, then a done pulse; optional long stall.
  initial begin
    tx_active_in = 1'b0;
    tx_done_in   = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_dv_out && !rst_n) begin
        @(posedge clk); #1 tx_active_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 tx_active_in = 1'b0; tx_done_in = 1'b1;
        served++;
        last_done_cyc = cyc;
        @(posedge clk); #1 tx_done_in = 1'b0;
        if (stall_en && (served % 32 == 5)) begin
          tx_active_in = 1'b1;
          repeat (50) @(posedge clk);
          #1 tx_active_in = 1'b0;
          stall_end_cyc = cyc;
          stall_en = 0;
          stall_seen = 1;
        end
      end
    end
  end
`else
  initial begin
    tx_active_in = 1'b0;
    tx_done_in   = 1'b0;
  end
`endif

  task automatic drive_block(input logic [511:0] blk, input int n_words, input bit push,
                             input logic [255:0] dig);
    @(posedge clk); #1;
    start_cyc = cyc;
    first_strobe_cyc = -1;
    if (push) begin
      exp_dig_q.push_back(dig);
`ifdef SHA256_TX_READBACK_EN
      for (int i = 0; i < 32; i++) exp_byte_q.push_back(dig[255 - 8*i -: 8]);
`endif
    end
    mp_dv_in   = 1'b1;
    mp_data_in = blk[511:480];
    for (int i = 0; i < n_words; i++) begin
      @(posedge clk); #1 mp_data_in = blk[511 - 32*i -: 32];
    end
    @(posedge clk); #1;
    mp_dv_in   = 1'b0;
    mp_data_in = '0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done_out && k < budget);
    if (!done_out) check_eq({tag, "_timeout"}, 256'(done_out), 256'(1));
    @(posedge clk); #1;
  endtask

  task automatic check_timing(input string tag);
    check_eq({tag, "_init"},   256'(init_cyc - start_cyc),  256'(0));
    check_eq({tag, "_round0"}, 256'(r0_cyc - start_cyc),    256'(17));
    check_eq({tag, "_update"}, 256'(upd_cyc - start_cyc),   256'(81));
    check_eq({tag, "_valid"},  256'(valid_cyc - start_cyc), 256'(83));
`ifdef SHA256_TX_READBACK_EN
    check_eq({tag, "_tx_first"}, 256'(first_strobe_cyc - start_cyc), 256'(83));
    check_eq({tag, "_done_after_tx"}, 256'(done_cyc - last_done_cyc), 256'(1));
    check_eq({tag, "_strobes"}, 256'(run_strobes), 256'(32));
`else
    check_eq({tag, "_done"}, 256'(done_cyc - start_cyc), 256'(83));
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rounds_before, err_before, init_before;
    rst_n      = 1'b1;
    mp_dv_in   = 1'b0;
    mp_data_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_eq("reset_ctrl", 256'({core_init_out, core_round_en_out, round_idx_out, w_t_out,
             core_update_out, digest_valid_out, tx_byte_out, tx_dv_out, busy_out,
             done_out, err_out}), 256'(0));
    check_eq("reset_digest", digest_out, 256'(0));

    // "abc" block with cycle-exact timing
    rounds_before = n_rounds;
    drive_block(BLK_ABC, 16, 1, DIG_ABC);
    wait_done("abc", 1000);
    check_timing("abc");
    check_eq("abc_w16", 256'(w16), 256'(32'h61626380));
    check_eq("abc_rounds", 256'(n_rounds - rounds_before), 256'(64));

    // reset held three cycles in the middle of the rounds
    rounds_before = n_rounds;
    drive_block(BLK_ABC, 16, 0, DIG_ABC);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_eq("midreset_reached_rounds", 256'(n_rounds > rounds_before), 256'(1));
    check_eq("midreset_ctrl", 256'({core_init_out, core_round_en_out, round_idx_out, w_t_out,
             core_update_out, digest_valid_out, tx_byte_out, tx_dv_out, busy_out,
             done_out, err_out}), 256'(0));
    check_eq("midreset_digest", digest_out, 256'(0));

    // empty message block
    drive_block(BLK_EMPTY, 16, 1, DIG_EMPTY);
    wait_done("empty", 1000);
    check_timing("empty");

    // burst truncated after 9 captured words
    rounds_before = n_rounds;
    err_before    = n_err;
    drive_block(BLK_ABC, 9, 0, DIG_ABC);
    repeat (100) @(posedge clk);
    #1;
    check_eq("trunc_err", 256'(n_err - err_before), 256'(1));
    check_eq("trunc_no_rounds", 256'(n_rounds - rounds_before), 256'(0));
    check_eq("trunc_digest_kept", digest_out, DIG_EMPTY);
    check_eq("trunc_busy", 256'(busy_out), 256'(0));
    check_eq("trunc_valid", 256'(digest_valid_out), 256'(0));

    // stray dv pulses during the rounds are ignored
    init_before = n_init;
    drive_block(BLK_ABC, 16, 1, DIG_ABC);
    repeat (10) @(posedge clk);
    #1 mp_dv_in = 1'b1; mp_data_in = 32'hdeadbeef;
    repeat (3) @(posedge clk);
    #1 mp_dv_in = 1'b0; mp_data_in = '0;
    wait_done("stray", 1000);
    check_eq("stray_single_init", 256'(n_init - init_before), 256'(1));
    check_eq("stray_digest_out", digest_out, DIG_ABC);

`ifdef SHA256_TX_READBACK_EN
    // UART busy for 50 cycles ahead of byte 5
    stall_en = 1;
    drive_block(BLK_EMPTY, 16, 1, DIG_EMPTY);
    wait_done("stall", 2000);
    check_eq("stall_seen", 256'(stall_seen), 256'(1));
    check_eq("byte5_after_stall", 256'(byte5_cyc >= stall_end_cyc), 256'(1));
    check_eq("stall_strobes", 256'(run_strobes), 256'(32));
    check_eq("tx_dv_while_active", 256'(n_tx_viol), 256'(0));
`else
    check_eq("no_tx_strobes", 256'(n_strobe), 256'(0));
`endif
    check_eq("sb_digest_drained", 256'(exp_dig_q.size()), 256'(0));
    check_eq("sb_bytes_drained", 256'(exp_byte_q.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
